// File: rtl/cla_serial_add16_ctrl.sv
// rtl/cla_serial_add16_ctrl.sv - nibble-serial WIDTH-bit add/subtract sequencer around one 4-bit CLA
//
// CLA_Adder4: 4-bit carry-lookahead adder.
//   A, B  : 4-bit operands
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out
//
// cla_serial_add16_ctrl: performs WIDTH-bit A+B or A-B over WIDTH/4 clock cycles.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake; in_ready high only while idle
//   op_a, op_b, sub     : operands and operation select, sampled on accept
//   out_valid/out_ready : result handshake; out_valid high only while done
//   result, cout, ovf   : sum/difference, final carry (1 = no borrow on subtract),
//                         signed overflow

module CLA_Adder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        Sum  = p ^ c[3:0];
        Cout = c[4];
    end
endmodule

module cla_serial_add16_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    LAST     = IW'(N - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    // Bit offset of the current nibble; shifting instead of a variable
    // part-select keeps the index arithmetic width-exact.
    logic [IW+1:0]    sh;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       add_sum;
    logic             add_cout;

    assign sh   = {idx_q, 2'b00};
    assign a_sh = a_q >> sh;
    assign b_sh = b_q >> sh;

    CLA_Adder4 u_cla (
        .A    (a_sh[3:0]),
        .B    (b_sh[3:0]),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B once, seed the carry with 1.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d = (result_q & ~(NIB_MASK << sh)) | (WIDTH'(add_sum) << sh);
                carry_d  = add_cout;
                if (idx_q == LAST) begin
                    cout_d  = add_cout;
                    // b_q already holds the inverted operand for subtract, so
                    // the same sign rule covers both operations.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
                    // Wrap to 0 so the nibble index never leaves the operand.
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/cla_serial_add16_ctrl.md
# cla_serial_add16_ctrl

Nibble-serial sequencer that performs WIDTH-bit add/subtract by reusing a single `CLA_Adder4` instance over WIDTH/4 cycles. Carry is held in a register between nibbles. The block sits between a requester (valid/ready input) and a consumer (valid/ready output). It is the first clocked user of the 4-bit CLA datapath and trades latency for area.

## Interface
- `WIDTH`, default 16: operand/result width.
  - Must be a multiple of 4 and ≥ 4.
  - N = WIDTH/4 nibble steps.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
  - Combinational from state: high only in IDLE.
- `op_a`, input, WIDTH: operand A, sampled on accept.
- `op_b`, input, WIDTH: operand B, sampled on accept.
- `sub`, input, 1: selects operation, sampled on accept.
  - 0: A+B.
  - 1: A−B.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes result.
- `result`, output, WIDTH: sum/difference.
- `cout`, output, 1: final carry out.
  - For subtract: 1 = no borrow.
- `ovf`, output, 1: two's-complement signed overflow.

## Operation
- Datapath:
  - Exactly one `CLA_Adder4` instance (`Cout`, `Sum`, `A`, `B`, `Cin`).
  - No other adder in the block.
- Registers:
  - `a_q`, `b_q` (WIDTH each).
  - `carry_q`.
  - `idx_q` (ceil(log2 N) bits, minimum 1).
  - `result`, `cout`, `ovf`.
  - State.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - `a_q`←`op_a`.
    - `b_q`←`sub ? ~op_b : op_b`.
    - `carry_q`←`sub`.
    - `idx_q`←0.
    - Next state → RUN.
- RUN, each cycle:
  - Adder A = `a_q[4*idx_q+:4]`, B = `b_q[4*idx_q+:4]`, Cin = `carry_q`.
  - `result[4*idx_q+:4]`←Sum.
  - `carry_q`←Cout.
  - `idx_q`←`idx_q`+1.
  - When `idx_q`==N−1:
    - `cout`←Cout.
    - `ovf`←(`a_q[WIDTH-1]`==`b_q[WIDTH-1]`) && (Sum[3]!=`a_q[WIDTH-1]`).
    - Next state → DONE.
- DONE:
  - `out_valid`=1.
  - `result`/`cout`/`ovf` held stable.
  - On `out_ready` → IDLE.
- Inputs are ignored in RUN and DONE. No request queuing.
- `in_valid` while `in_ready`=0 has no effect. The requester must hold it.
- `result` contents are meaningful only while `out_valid`=1. Partial nibbles are written during RUN.

## Timing
- Reset (asynchronous, immediate on `rst_n` low) forces:
  - State to IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `result`=0, `cout`=0, `ovf`=0.
  - `carry_q`=0, `idx_q`=0, `a_q`=`b_q`=0.
- Reset mid-RUN or in DONE aborts the operation. No `out_valid` follows.
- Latency:
  - Accept at edge T.
  - Nibble k is written at edge T+1+k.
  - `out_valid` rises after edge T+N (N cycles after accept).
- DONE→IDLE on the edge where `out_valid && out_ready`.
  - `in_ready` returns 1 the following cycle. There is no same-cycle accept.
- Minimum issue interval is N+2 cycles with `out_ready` tied high.
- `out_ready` high before DONE has no effect.
- Carry propagates across nibbles only through `carry_q`. There is no combinational path from input ports to outputs except `in_ready`/`out_valid` from state.

## Test plan
- Reset:
  - Accept 0x1234+0x0001, then pull `rst_n` low after 2 cycles.
  - Required: immediately `out_valid`=0, `in_ready`=1, `result`=0.
  - Required: no `out_valid` after release.
- Basic add:
  - Stimulus: 0x1234+0x0FCD, `sub`=0.
  - Required: `result`=0x2201, `cout`=0, `ovf`=0.
  - Required: `out_valid` exactly 4 cycles after accept edge.
- Full carry ripple:
  - 0xFFFF+0x0001 → `result`=0x0000, `cout`=1, `ovf`=0.
  - 0x7FFF+0x0001 → `result`=0x8000, `cout`=0, `ovf`=1.
- Subtract:
  - 0x0003−0x0005 → `result`=0xFFFE, `cout`=0, `ovf`=0.
  - 0x8000−0x0001 → `result`=0x7FFF, `cout`=1, `ovf`=1.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE while driving new `in_valid` with different operands.
  - Required: `result` stable, `in_ready`=0, new request not taken.
  - After the `out_ready` pulse: IDLE next cycle; the held request is accepted the cycle after, and its result is correct.
- Exhaustive:
  - `WIDTH`=4 instance, all 256 A,B pairs with `sub`=0 and `sub`=1.
  - Required: {`cout`,`result`} equals A+B, resp. A+~B+1, every case.
  - Required: `out_valid` 1 cycle after each accept.
